nrs_seq_gen: RTL and testbench

Consumer of the NRS c_init word: loads the 28-bit `cinit` delivered by the c_init generator and runs the length-31 Gold-sequence LFSR pair (x1, x2) past the N_c = 1600 discard and the NB-IoT offset m' = m + 109. It then emits the two QPSK sign-bit pairs for NRS resource elements m = 0 and m = 1 of the current OFDM symbol. The block sits between the c_init generator and the NRS RE mapper, and throttles the upstream generator through `ready`.

---
 rtl/nrs_seq_gen_if.sv | 28 ++
 rtl/nrs_seq_gen.sv | 106 ++++++++++
 tb/tb_nrs_seq_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/nrs_seq_gen_if.sv
// Handshake/output bundle between the c_init generator, the NRS sequence
// generator and the NRS RE mapper.
interface nrs_seq_gen_if;
    logic [27:0] cinit;
    logic        cinit_valid;
    logic        ready;
    logic [1:0]  nrs_bits;
    logic        nrs_idx;
    logic        nrs_valid;

    modport master (
        output cinit,
        output cinit_valid,
        input  ready,
        input  nrs_bits,
        input  nrs_idx,
        input  nrs_valid
    );

    modport slave (
        input  cinit,
        input  cinit_valid,
        output ready,
        output nrs_bits,
        output nrs_idx,
        output nrs_valid
    );
endinterface

// File: rtl/nrs_seq_gen.sv
// NRS Gold-sequence generator: loads c_init, advances the x1/x2 LFSR pair past
// the discard plus NB-IoT offset, then emits the sign-bit pairs for m = 0 and m = 1.
module nrs_seq_gen #(
    parameter int P     = 18,
    parameter int NC    = 1600,
    parameter int M_OFF = 109
) (
    input  logic          clk,
    input  logic          rst,
    nrs_seq_gen_if.slave  bus
);
    localparam int A  = NC + 2 * M_OFF;
    localparam int N  = A / P;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADVANCE,
        ST_OUT0,
        ST_OUT1
    } state_t;

    state_t        state_q;
    logic [30:0]   x1_q;
    logic [30:0]   x2_q;
    logic [CW-1:0] cnt_q;
    logic          ready_q;
    logic          nrs_valid_q;
    logic          nrs_idx_q;
    logic [1:0]    nrs_bits_q;

    logic [30:0]   x1_d;
    logic [30:0]   x2_d;
    logic [3:0]    c_bits;

    // P single steps unrolled; bit i of each register holds x(n+i).
    always_comb begin
        x1_d = x1_q;
        x2_d = x2_q;
        for (int i = 0; i < P; i++) begin
            x1_d = {x1_d[3] ^ x1_d[0], x1_d[30:1]};
            x2_d = {x2_d[3] ^ x2_d[2] ^ x2_d[1] ^ x2_d[0], x2_d[30:1]};
        end
    end

    assign c_bits = x1_q[3:0] ^ x2_q[3:0];

    // ready_q lags the return to IDLE by one cycle so the busy window is N+3.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            x1_q        <= '0;
            x2_q        <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            nrs_valid_q <= 1'b0;
            nrs_idx_q   <= 1'b0;
            nrs_bits_q  <= 2'b00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    nrs_valid_q <= 1'b0;
                    nrs_idx_q   <= 1'b0;
                    nrs_bits_q  <= 2'b00;
                    if (ready_q && bus.cinit_valid) begin
                        x1_q    <= 31'd1;
                        x2_q    <= {3'b000, bus.cinit};
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= ST_ADVANCE;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_ADVANCE: begin
                    x1_q  <= x1_d;
                    x2_q  <= x2_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_q <= ST_OUT0;
                    end
                end
                ST_OUT0: begin
                    nrs_valid_q <= 1'b1;
                    nrs_idx_q   <= 1'b0;
                    nrs_bits_q  <= {c_bits[0], c_bits[1]};
                    state_q     <= ST_OUT1;
                end
                ST_OUT1: begin
                    nrs_valid_q <= 1'b1;
                    nrs_idx_q   <= 1'b1;
                    nrs_bits_q  <= {c_bits[2], c_bits[3]};
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.nrs_valid = nrs_valid_q;
    assign bus.nrs_idx   = nrs_idx_q;
    assign bus.nrs_bits  = nrs_bits_q;
endmodule

// File: tb/tb_nrs_seq_gen.sv
// Directed bench for nrs_seq_gen: P=18 and P=1 instances checked cycle by cycle
// against a bit-serial Gold-sequence model of c(218..221).
module tb_nrs_seq_gen;
    localparam int N18 = 101;
    localparam int N1  = 1818;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    nrs_seq_gen_if if18 ();
    nrs_seq_gen_if if1 ();

    nrs_seq_gen #(.P(18)) dut18 (.clk(clk), .rst(rst), .bus(if18.slave));
    nrs_seq_gen #(.P(1))  dut1  (.clk(clk), .rst(rst), .bus(if1.slave));

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // c(n) = x1(n+1600) ^ x2(n+1600) from the recurrences; returns {c218,c219,c220,c221}.
    function automatic logic [3:0] gold4(input logic [27:0] c);
        bit x1 [0:1852];
        bit x2 [0:1852];
        logic [3:0] r;
        for (int n = 0; n < 31; n++) begin
            x1[n] = (n == 0);
            x2[n] = (n < 28) ? c[n] : 1'b0;
        end
        for (int n = 0; n + 31 <= 1852; n++) begin
            x1[n+31] = x1[n+3] ^ x1[n];
            x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
        end
        for (int i = 0; i < 4; i++) begin
            r[3-i] = x1[1818+i] ^ x2[1818+i];
        end
        return r;
    endfunction

    task automatic check_dut(input string nm, input int k, input int n, input int rst_k,
                             input logic [3:0] e, input logic v, input logic r,
                             input logic idx, input logic [1:0] bits);
        logic aborted, exp_v, exp_r;
        aborted = (rst_k >= 0) && (k > rst_k);
        exp_v   = !aborted && (k == n + 1 || k == n + 2);
        exp_r   = aborted || (k >= n + 3);
        check_eq({nm, "_valid"}, 32'(v), 32'(exp_v));
        check_eq({nm, "_ready"}, 32'(r), 32'(exp_r));
        if (exp_v) begin
            check_eq({nm, "_idx"}, 32'(idx), 32'(k == n + 2));
            check_eq({nm, "_bits"}, 32'(bits), (k == n + 1) ? 32'(e[3:2]) : 32'(e[1:0]));
        end
    endtask

    // Offers c when ready, then checks every cycle k after the acceptance edge T.
    task automatic run_seq(input logic [27:0] c, input bit use_p1, input int inject_k,
                           input logic [27:0] inject_c, input int rst_k);
        logic [3:0] e;
        int guard;
        int kmax;
        e = gold4(c);
        guard = 0;
        while (!(if18.ready && (!use_p1 || if1.ready)) && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("ready_wait", 32'(guard < 4000), 32'd1);
        if18.cinit = c;
        if18.cinit_valid = 1'b1;
        if (use_p1) begin
            if1.cinit = c;
            if1.cinit_valid = 1'b1;
        end
        kmax = use_p1 ? N1 + 3 : N18 + 3;
        for (int k = 0; k <= kmax; k++) begin
            @(negedge clk);
            if (k == 0) begin
                if18.cinit_valid = 1'b0;
                if1.cinit_valid  = 1'b0;
            end
            if (k == inject_k) begin
                if18.cinit = inject_c;
                if18.cinit_valid = 1'b1;
            end
            if (k == inject_k + 1) if18.cinit_valid = 1'b0;
            if (k == rst_k) rst = 1'b0;
            if (k == rst_k + 1) rst = 1'b1;
            check_dut("p18", k, N18, rst_k, e, if18.nrs_valid, if18.ready, if18.nrs_idx, if18.nrs_bits);
            if (use_p1)
                check_dut("p1", k, N1, -1, e, if1.nrs_valid, if1.ready, if1.nrs_idx, if1.nrs_bits);
        end
        $display("run cinit=%07h exp_bits=%04b p1=%0d inject=%0d rst_at=%0d", c, e, use_p1, inject_k, rst_k);
    endtask

    initial begin
        int cells [6];
        int nss [4];
        logic [27:0] cv;
        cells = '{0, 1, 2, 167, 250, 503};
        nss   = '{0, 9, 12, 19};

        // Reset dominance with a pending cinit_valid.
        if18.cinit = 28'h0003401;
        if18.cinit_valid = 1'b1;
        if1.cinit = 28'h0003401;
        if1.cinit_valid = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("rst_ready", 32'(if18.ready), 32'd1);
            check_eq("rst_valid", 32'(if18.nrs_valid), 32'd0);
            check_eq("rst_bits", 32'(if18.nrs_bits), 32'd0);
            check_eq("rst_idx", 32'(if18.nrs_idx), 32'd0);
            check_eq("rst_valid_p1", 32'(if1.nrs_valid), 32'd0);
        end
        if18.cinit_valid = 1'b0;
        if1.cinit_valid  = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            check_eq("post_rst_valid", 32'(if18.nrs_valid | if1.nrs_valid), 32'd0);
            check_eq("post_rst_ready", 32'(if18.ready), 32'd1);
        end
        $display("reset dominance done");

        // Single run, then busy rejection, reset abort and recovery, all back to back.
        run_seq(28'd13313, 1'b0, -1, 28'd0, -1);
        run_seq(28'h0003401, 1'b0, 50, 28'hABCDEF1, -1);
        run_seq(28'h5A5A5A5, 1'b0, -1, 28'd0, 60);
        run_seq(28'd13313, 1'b0, -1, 28'd0, -1);

        // Sampled sweep of N_cell_ID, ns, l.
        foreach (cells[ci]) begin
            foreach (nss[si]) begin
                for (int l = 5; l <= 6; l++) begin
                    cv = 28'(1024 * (7 * (nss[si] + 1) + l + 1) * (2 * cells[ci] + 1) + 2 * cells[ci] + 1);
                    run_seq(cv, 1'b0, -1, 28'd0, -1);
                end
            end
        end

        // P=1 versus P=18 on edge and random values.
        run_seq(28'd0, 1'b1, -1, 28'd0, -1);
        run_seq(28'hFFFFFFF, 1'b1, -1, 28'd0, -1);
        run_seq(28'd13313, 1'b1, -1, 28'd0, -1);
        for (int i = 0; i < 5; i++) begin
            cv = 28'($urandom);
            run_seq(cv, 1'b1, -1, 28'd0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
